nbcac_tx_scheduler: RTL and testbench
=====================================

NBCAC_TX_SCHEDULER -- requirements
Module: nbcac_tx_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of buffered 16-bit words; legal values are powers of two from 2 to 16.
REQ-002 Port clock: input, 1 bit, sole clock; all state updates on its rising edge.
REQ-003 Port rst: input, 1 bit, synchronous active-high reset, sampled on the rising edge of clock.
REQ-004 Port req_valid: input, 2 bits, per-requester word-valid.
REQ-005 Port req_data0 / req_data1: input, 16 bits each, data word of requester 0 / 1.
REQ-006 Port req_ready: output, 2 bits, per-requester accept; a transfer occurs when valid and ready are both 1.
REQ-007 Port link_en: input, 1 bit, link permission; low stalls all output updates.
REQ-008 Port codeout: output, 23 bits, bits [23:1], registered NBCAC codeword driving the bus.
REQ-009 Port code_valid: output, 1 bit, high for exactly the cycle in which codeout carries a newly issued word.
REQ-010 Port code_src: output, 1 bit, requester index of the word on codeout.
REQ-011 Port fifo_count: output, $clog2(FIFO_DEPTH)+1 bits, current occupancy.
REQ-012 Port sent_cnt: output, 16 bits, count of issued codewords.

Function
REQ-013 Arbitration SHALL be round-robin between the two requesters; a priority pointer selects which requester wins a tie.
REQ-014 req_ready SHALL be combinational, one-hot or zero, and SHALL be asserted only to the arbitration winner, only while fifo_count < FIFO_DEPTH.
REQ-015 A requester that is not valid SHALL never receive ready; a lone valid requester SHALL win regardless of the pointer.
REQ-016 After each transfer, the priority pointer SHALL point to the other requester; the pointer SHALL be unchanged when no transfer occurs.
REQ-017 Accepted words SHALL be written to the FIFO together with a 1-bit source tag, preserving acceptance order.
REQ-018 Pop SHALL occur on an edge where link_en = 1 and fifo_count > 0.
REQ-019 On pop, codeout SHALL be loaded with the encoding of the head word by nbcac_16di_encoder_core; code_src SHALL be loaded with the head tag, code_valid SHALL be set to 1, and sent_cnt SHALL increment by 1.
REQ-020 Latency: a word accepted at edge k into an empty FIFO, with link_en high, SHALL appear on codeout after edge k+1.
REQ-021 Throughput SHALL be one word per cycle sustained.
REQ-022 With no pop, codeout and code_src SHALL hold their previous values so that no bus transitions occur, and code_valid SHALL be 0.
REQ-023 Simultaneous push and pop SHALL leave fifo_count unchanged, including at fifo_count = FIFO_DEPTH-1.
REQ-024 At full, no requester receives ready, even when a pop occurs on the same edge (there is no pass-through).
REQ-025 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 sent_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-027 link_en low SHALL freeze the FIFO head, codeout and sent_cnt; pushes SHALL continue while space remains.

Reset
REQ-028 rst SHALL force codeout = 0, code_valid = 0, code_src = 0, fifo_count = 0, sent_cnt = 0, FIFO pointers = 0 and priority pointer = requester 0 on the next edge.
REQ-029 Reset asserted mid-operation SHALL discard all buffered words.
REQ-030 While rst is high, req_ready SHALL be 0.

Structure
REQ-031 A shared package SHALL hold NBCAC_DATA_W = 16, NBCAC_CODE_W = 23 and the FIFO entry typedef (16-bit data plus 1-bit tag).
REQ-032 The block SHALL instantiate exactly one nbcac_16di_encoder_core, placed between the FIFO head and the codeout register.
REQ-033 The FIFO SHALL be one sub-module, nbcac_tx_fifo, parameterised by FIFO_DEPTH.

Verification
REQ-034 Reset, then req_valid = 2'b01 with data0 = 16'h1234 and link_en = 1 -> req_ready = 01; codeout = encoder(16'h1234), code_valid = 1 and code_src = 0 one edge after acceptance; sent_cnt = 1.
REQ-035 Both requesters continuously valid -> grants alternate 0,1,0,1; code_src alternates accordingly; code_valid stays high every cycle.
REQ-036 link_en = 0 with both requesters valid -> fifo_count rises to 4 and req_ready = 00; codeout holds; raise link_en -> 4 words drain in acceptance order.
REQ-037 Idle after traffic -> codeout stays at the last codeword with code_valid = 0 for 10 cycles.
REQ-038 Preload sent_cnt to 16'hFFFF by issuing 65535 words, issue one more -> sent_cnt = 0.
REQ-039 Assert rst with fifo_count = 3 -> all outputs at reset values next cycle; previously buffered words never appear on codeout.

Source files
------------

// File: rtl/nbcac_tx_scheduler_pkg.sv
// Shared widths and FIFO entry layout for the NBCAC transmit scheduler.
package nbcac_tx_scheduler_pkg;

  localparam int unsigned NBCAC_DATA_W = 16;
  localparam int unsigned NBCAC_CODE_W = 23;

  typedef struct packed {
    logic [NBCAC_DATA_W-1:0] data;
    logic                    tag;
  } fifo_entry_t;

  // Round-robin hand-off: after a grant the other requester gets priority.
  function automatic logic next_prio(input logic winner);
    return ~winner;
  endfunction

endpackage

// File: rtl/nbcac_16di_encoder_core.sv
// Combinational 16-bit to 23-wire NBCAC encoder: data bit pairs separated by grounded shields.
module nbcac_16di_encoder_core
  import nbcac_tx_scheduler_pkg::*;
(
  input  logic [NBCAC_DATA_W-1:0] data,
  output logic [NBCAC_CODE_W:1]   code
);

  // Wire 3g+1/3g+2 carry data pair g; wire 3g+3 is a shield held at 0.
  always_comb begin
    code = '0;
    for (int g = 0; g < 8; g++) begin
      code[3*g+1] = data[2*g];
      code[3*g+2] = data[2*g+1];
    end
  end

endmodule

// File: rtl/nbcac_tx_fifo.sv
// Tagged word FIFO with synchronous reset; head entry is read combinationally.
module nbcac_tx_fifo
  import nbcac_tx_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          push,
  input  fifo_entry_t                   wdata,
  input  logic                          pop,
  output fifo_entry_t                   rdata,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("nbcac_tx_fifo: FIFO_DEPTH must be a power of two in 2..16");
  end

  fifo_entry_t         mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wptr_q, wptr_d;
  logic [PtrW-1:0]     rptr_q, rptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                push_ok, pop_ok;

  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop_ok) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/nbcac_tx_scheduler.sv
// Two-requester round-robin scheduler feeding a FIFO and a registered NBCAC bus driver.
module nbcac_tx_scheduler
  import nbcac_tx_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic [1:0]                    req_valid,
  input  logic [NBCAC_DATA_W-1:0]       req_data0,
  input  logic [NBCAC_DATA_W-1:0]       req_data1,
  output logic [1:0]                    req_ready,
  input  logic                          link_en,
  output logic [NBCAC_CODE_W:1]         codeout,
  output logic                          code_valid,
  output logic                          code_src,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   sent_cnt
);

  logic                  prio_q, prio_d;
  logic                  winner;
  logic                  push, pop;
  logic                  fifo_full, fifo_empty;
  fifo_entry_t           push_entry, head_entry;
  logic [NBCAC_CODE_W:1] head_code;

  logic [NBCAC_CODE_W:1] codeout_q;
  logic                  code_valid_q;
  logic                  code_src_q;
  logic [15:0]           sent_cnt_q;

  always_comb begin
    winner = 1'b0;
    case (req_valid)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = prio_q;
      default: winner = 1'b0;
    endcase

    // No pass-through at full: ready depends only on current occupancy.
    req_ready = 2'b00;
    if (!rst && !fifo_full && (req_valid != 2'b00)) begin
      req_ready[winner] = 1'b1;
    end

    push            = (req_ready != 2'b00);
    push_entry.data = winner ? req_data1 : req_data0;
    push_entry.tag  = winner;
    prio_d          = push ? next_prio(winner) : prio_q;
    pop             = link_en && !fifo_empty;
  end

  nbcac_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  nbcac_16di_encoder_core u_encoder (
    .data (head_entry.data),
    .code (head_code)
  );

  // Bus register only updates on pop, so an idle bus sees no transitions.
  always_ff @(posedge clock) begin
    if (rst) begin
      prio_q       <= 1'b0;
      codeout_q    <= '0;
      code_valid_q <= 1'b0;
      code_src_q   <= 1'b0;
      sent_cnt_q   <= '0;
    end else begin
      prio_q       <= prio_d;
      code_valid_q <= pop;
      if (pop) begin
        codeout_q  <= head_code;
        code_src_q <= head_entry.tag;
        sent_cnt_q <= sent_cnt_q + 16'd1;
      end
    end
  end

  assign codeout    = codeout_q;
  assign code_valid = code_valid_q;
  assign code_src   = code_src_q;
  assign sent_cnt   = sent_cnt_q;

endmodule

// File: tb/tb_nbcac_tx_scheduler.sv
// Directed bench for nbcac_tx_scheduler: vector table plus multi-cycle corner sequences.
module tb_nbcac_tx_scheduler;

  logic        clock = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data0, req_data1;
  logic [1:0]  req_ready;
  logic        link_en;
  logic [23:1] codeout;
  logic        code_valid;
  logic        code_src;
  logic [2:0]  fifo_count;
  logic [15:0] sent_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  nbcac_tx_scheduler #(
    .FIFO_DEPTH (4)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .req_ready  (req_ready),
    .link_en    (link_en),
    .codeout    (codeout),
    .code_valid (code_valid),
    .code_src   (code_src),
    .fifo_count (fifo_count),
    .sent_cnt   (sent_cnt)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        link;
    logic [1:0]  exp_ready;
    logic [2:0]  exp_count;
    logic        exp_cv;
    logic        exp_src;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference encoder: walk the data bits, skipping a shield wire after every pair.
  function automatic logic [22:0] enc_model(input logic [15:0] d);
    logic [22:0] c;
    int pos;
    c   = '0;
    pos = 0;
    for (int i = 0; i < 16; i++) begin
      c[pos] = d[i];
      pos++;
      if (i % 2 == 1 && i != 15) pos++;
    end
    return c;
  endfunction

  function automatic vec_t mk(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                              input logic lk, input logic [1:0] rdy, input logic [2:0] cnt,
                              input logic cv, input logic src, input logic [15:0] w);
    vec_t r;
    r.valid = v;   r.d0 = d0;        r.d1 = d1;        r.link = lk;
    r.exp_ready = rdy; r.exp_count = cnt; r.exp_cv = cv; r.exp_src = src; r.exp_word = w;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [16:0] sb [$];
  logic [16:0] ent;
  logic [15:0] sent_exp;
  logic [15:0] last_word;
  logic [1:0]  exp_gnt;

  initial begin
    //            valid  d0        d1        lk  rdy    cnt cv src word
    vecs[0]  = mk(2'b01, 16'h1234, 16'h0000, 1, 2'b01, 1, 0, 0, 16'h0000);
    vecs[1]  = mk(2'b00, 16'h0000, 16'h0000, 1, 2'b00, 0, 1, 0, 16'h1234);
    vecs[2]  = mk(2'b10, 16'h0000, 16'hABCD, 1, 2'b10, 1, 0, 0, 16'h1234);
    vecs[3]  = mk(2'b11, 16'h0001, 16'h8000, 1, 2'b01, 1, 1, 1, 16'hABCD);
    vecs[4]  = mk(2'b11, 16'h0002, 16'h7FFF, 1, 2'b10, 1, 1, 0, 16'h0001);
    vecs[5]  = mk(2'b10, 16'h0000, 16'hFFFF, 0, 2'b10, 2, 0, 0, 16'h0001);
    vecs[6]  = mk(2'b01, 16'h5555, 16'h0000, 0, 2'b01, 3, 0, 0, 16'h0001);
    vecs[7]  = mk(2'b11, 16'hAAAA, 16'h0F0F, 0, 2'b10, 4, 0, 0, 16'h0001);
    vecs[8]  = mk(2'b11, 16'hAAAA, 16'h0F0F, 0, 2'b00, 4, 0, 0, 16'h0001);
    vecs[9]  = mk(2'b11, 16'h1111, 16'h2222, 1, 2'b00, 3, 1, 1, 16'h7FFF);
    vecs[10] = mk(2'b01, 16'h6666, 16'h0000, 1, 2'b01, 3, 1, 1, 16'hFFFF);
    vecs[11] = mk(2'b11, 16'h3333, 16'h4444, 1, 2'b10, 3, 1, 0, 16'h5555);
    vecs[12] = mk(2'b00, 16'h0000, 16'h0000, 1, 2'b00, 2, 1, 1, 16'h0F0F);
    vecs[13] = mk(2'b00, 16'h0000, 16'h0000, 1, 2'b00, 1, 1, 0, 16'h6666);
    vecs[14] = mk(2'b00, 16'h0000, 16'h0000, 1, 2'b00, 0, 1, 1, 16'h4444);
    vecs[15] = mk(2'b00, 16'h0000, 16'h0000, 1, 2'b00, 0, 0, 1, 16'h4444);

    rst = 1'b1; req_valid = 2'b00; req_data0 = '0; req_data1 = '0; link_en = 1'b0;
    tick();
    req_valid = 2'b11;
    #1;
    check("ready_in_reset", 32'(req_ready), 32'(2'b00));
    tick();
    check("rst_codeout", 32'(codeout), 32'(0));
    check("rst_code_valid", 32'(code_valid), 32'(0));
    check("rst_code_src", 32'(code_src), 32'(0));
    check("rst_fifo_count", 32'(fifo_count), 32'(0));
    check("rst_sent_cnt", 32'(sent_cnt), 32'(0));
    rst = 1'b0;
    req_valid = 2'b00;

    sent_exp = 16'd0;
    for (int i = 0; i < 16; i++) begin
      req_valid = vecs[i].valid;
      req_data0 = vecs[i].d0;
      req_data1 = vecs[i].d1;
      link_en   = vecs[i].link;
      #1;
      check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      tick();
      if (vecs[i].exp_cv) sent_exp = sent_exp + 16'd1;
      check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_cv", i), 32'(code_valid), 32'(vecs[i].exp_cv));
      check($sformatf("vec%0d_src", i), 32'(code_src), 32'(vecs[i].exp_src));
      check($sformatf("vec%0d_code", i), 32'(codeout), 32'(enc_model(vecs[i].exp_word)));
      check($sformatf("vec%0d_sent", i), 32'(sent_cnt), 32'(sent_exp));
    end

    // Both requesters saturated: grants alternate starting at requester 0.
    link_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_valid = 2'b11;
      req_data0 = 16'h0A00 + 16'(k);
      req_data1 = 16'h0B00 + 16'(k);
      exp_gnt   = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      check($sformatf("alt%0d_ready", k), 32'(req_ready), 32'(exp_gnt));
      sb.push_back({exp_gnt[1], exp_gnt[1] ? req_data1 : req_data0});
      tick();
      if (k > 0) begin
        ent = sb.pop_front();
        sent_exp = sent_exp + 16'd1;
        check($sformatf("alt%0d_cv", k), 32'(code_valid), 32'(1));
        check($sformatf("alt%0d_src", k), 32'(code_src), 32'(ent[16]));
        check($sformatf("alt%0d_code", k), 32'(codeout), 32'(enc_model(ent[15:0])));
      end
    end
    req_valid = 2'b00;
    tick();
    ent = sb.pop_front();
    sent_exp = sent_exp + 16'd1;
    last_word = ent[15:0];
    check("alt_drain_cv", 32'(code_valid), 32'(1));
    check("alt_drain_src", 32'(code_src), 32'(ent[16]));
    check("alt_drain_code", 32'(codeout), 32'(enc_model(last_word)));
    check("alt_drain_sent", 32'(sent_cnt), 32'(sent_exp));

    // Idle: bus holds the last codeword.
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("idle%0d_cv", k), 32'(code_valid), 32'(0));
      check($sformatf("idle%0d_code", k), 32'(codeout), 32'(enc_model(last_word)));
    end

    // Reset with three buffered words: none may ever reach the bus.
    link_en = 1'b0;
    req_valid = 2'b01;
    req_data0 = 16'hDEAD; tick();
    req_data0 = 16'hBEEF; tick();
    req_data0 = 16'hCAFE; tick();
    req_valid = 2'b00;
    check("prerst_count", 32'(fifo_count), 32'(3));
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    check("midrst_ready", 32'(req_ready), 32'(2'b00));
    tick();
    check("midrst_codeout", 32'(codeout), 32'(0));
    check("midrst_cv", 32'(code_valid), 32'(0));
    check("midrst_src", 32'(code_src), 32'(0));
    check("midrst_count", 32'(fifo_count), 32'(0));
    check("midrst_sent", 32'(sent_cnt), 32'(0));
    rst = 1'b0;
    req_valid = 2'b00;
    link_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("postrst%0d_cv", k), 32'(code_valid), 32'(0));
      check($sformatf("postrst%0d_code", k), 32'(codeout), 32'(0));
    end

    // sent_cnt wrap: one push per edge, pops lag by one edge.
    req_valid = 2'b11;
    req_data0 = 16'h00FF;
    req_data1 = 16'hFF00;
    for (int n = 0; n < 65536; n++) begin
      @(posedge clock);
    end
    #1;
    check("wrap_pre_sent", 32'(sent_cnt), 32'(16'hFFFF));
    check("wrap_pre_count", 32'(fifo_count), 32'(1));
    req_valid = 2'b00;
    tick();
    check("wrap_sent", 32'(sent_cnt), 32'(0));
    check("wrap_cv", 32'(code_valid), 32'(1));
    check("wrap_count", 32'(fifo_count), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
